// File: rtl/pd_dw_nr_pwr_acc_pkg.sv
// pd_dw_nr_pkg: shared defaults and helpers for the NR power-detect path
package pd_dw_nr_pkg;
  localparam int PD_NUM_CH = 4;
  localparam int PD_IQ_W = 16;
  localparam int PD_ACC_W = 48;
  localparam int PD_NUM_SYM = 280;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic logic [63:0] sat_lim(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction
endpackage

// File: rtl/pd_dw_nr_pwr_acc_if.sv
// pd_dw_nr_pwr_acc_if: sample input and result-RAM write port of the power accumulator
interface pd_dw_nr_pwr_acc_if
  import pd_dw_nr_pkg::*;
#(
  parameter int NUM_CH = PD_NUM_CH,
  parameter int IQ_W = PD_IQ_W,
  parameter int ACC_W = PD_ACC_W,
  parameter int NUM_SYM = PD_NUM_SYM
);
  localparam int CH_W = clog2(NUM_CH) > 1 ? clog2(NUM_CH) : 1;
  localparam int SYM_W = clog2(NUM_SYM);
  logic i_fram;
  logic i_vld;
  logic i_last;
  logic [2*IQ_W-1:0] i_data;
  logic i_avg_en;
  logic [4:0] i_log2n;
  logic o_we;
  logic [SYM_W+CH_W-1:0] o_addr;
  logic [ACC_W-1:0] o_din;
  logic o_ovf;
  modport master (output i_fram, i_vld, i_last, i_data, i_avg_en, i_log2n, input o_we, o_addr, o_din, o_ovf);
  modport slave (input i_fram, i_vld, i_last, i_data, i_avg_en, i_log2n, output o_we, o_addr, o_din, o_ovf);
endinterface

// File: rtl/pd_dw_nr_pwr_acc_sq_sum.sv
// pd_dw_nr_sq_sum: two-stage I^2+Q^2 with valid/ch/last/fram sideband
module pd_dw_nr_sq_sum #(
  parameter int IQ_W = 16,
  parameter int CH_W = 2
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic vld,
  input  logic fram,
  input  logic last,
  input  logic [CH_W-1:0] ch,
  input  logic [2*IQ_W-1:0] data,
  output logic p_vld,
  output logic p_fram,
  output logic p_last,
  output logic [CH_W-1:0] p_ch,
  output logic [2*IQ_W-1:0] p
);
  logic signed [2*IQ_W-1:0] i_x, q_x;
  logic [2*IQ_W-1:0] ii, qq;
  logic s1_vld, s1_fram, s1_last;
  logic [CH_W-1:0] s1_ch;
  assign i_x = {{IQ_W{data[2*IQ_W-1]}}, data[2*IQ_W-1:IQ_W]};
  assign q_x = {{IQ_W{data[IQ_W-1]}}, data[IQ_W-1:0]};
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      {s1_vld, s1_fram, s1_last, s1_ch, ii, qq} <= '0;
      {p_vld, p_fram, p_last, p_ch, p} <= '0;
    end else begin
      {s1_vld, s1_fram, s1_last, s1_ch} <= {vld, fram, last, ch};
      ii <= i_x * i_x;
      qq <= q_x * q_x;
      {p_vld, p_fram, p_last, p_ch} <= {s1_vld, s1_fram, s1_last, s1_ch};
      p <= ii + qq;
    end
endmodule

// File: rtl/pd_dw_nr_pwr_acc.sv
// pd_dw_nr_pwr_acc: per-channel I^2+Q^2 accumulation over a symbol, one saturated
// (optionally averaged) result per channel per symbol written at {sym, ch}
module pd_dw_nr_pwr_acc
  import pd_dw_nr_pkg::*;
#(
  parameter int NUM_CH = PD_NUM_CH,
  parameter int IQ_W = PD_IQ_W,
  parameter int ACC_W = PD_ACC_W,
  parameter int NUM_SYM = PD_NUM_SYM
) (
  input logic sys_clk,
  input logic sys_rst_n,
  pd_dw_nr_pwr_acc_if.slave bus
);
  localparam int CH_W = clog2(NUM_CH) > 1 ? clog2(NUM_CH) : 1;
  localparam int SYM_W = clog2(NUM_SYM);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(NUM_SYM - 1);
  localparam logic [ACC_W-1:0] LIM = ACC_W'(sat_lim(ACC_W));
  logic [CH_W-1:0] ch_cnt, ch_tag, p_ch, s3_ch;
  logic [SYM_W-1:0] sym_cnt, sym_out;
  logic p_vld, p_fram, p_last, s3_vld, s3_fram, s3_last;
  logic [2*IQ_W-1:0] p, s3_p;
  logic [ACC_W-1:0] acc [NUM_CH];
  logic [ACC_W-1:0] base, acc_new;
  logic [ACC_W:0] sum;
  logic sat, emit;
  // a frame-start sample is always channel 0, whatever the counter says
  assign ch_tag = bus.i_fram ? '0 : ch_cnt;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) ch_cnt <= '0;
    else if (bus.i_vld) ch_cnt <= ch_tag == CH_LAST ? '0 : ch_tag + CH_W'(1);
  pd_dw_nr_sq_sum #(.IQ_W(IQ_W), .CH_W(CH_W)) u_sq_sum (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .vld(bus.i_vld), .fram(bus.i_fram), .last(bus.i_last), .ch(ch_tag), .data(bus.i_data),
    .p_vld(p_vld), .p_fram(p_fram), .p_last(p_last), .p_ch(p_ch), .p(p)
  );
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) {s3_vld, s3_fram, s3_last, s3_ch, s3_p} <= '0;
    else {s3_vld, s3_fram, s3_last, s3_ch, s3_p} <= {p_vld, p_fram, p_last, p_ch, p};
  assign base = s3_fram ? '0 : acc[s3_ch];
  assign sum = {1'b0, base} + {{(ACC_W+1-2*IQ_W){1'b0}}, s3_p};
  assign sat = sum[ACC_W];
  assign acc_new = sat ? LIM : sum[ACC_W-1:0];
  assign emit = s3_vld & s3_last;
  assign sym_out = s3_fram ? '0 : sym_cnt;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
      sym_cnt <= '0;
    end else if (s3_vld) begin
      for (int k = 0; k < NUM_CH; k++)
        if (k == int'(s3_ch)) acc[k] <= s3_last ? '0 : acc_new;
        else if (s3_fram) acc[k] <= '0;
      sym_cnt <= emit && s3_ch == CH_LAST ? (sym_out == SYM_LAST ? '0 : sym_out + SYM_W'(1)) : sym_out;
    end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      bus.o_we <= 1'b0;
      bus.o_addr <= '0;
      bus.o_din <= '0;
      bus.o_ovf <= 1'b0;
    end else begin
      bus.o_we <= emit;
      if (emit) bus.o_addr <= {sym_out, s3_ch};
      if (emit) bus.o_din <= bus.i_avg_en ? acc_new >> bus.i_log2n : acc_new;
      if (s3_vld) bus.o_ovf <= (bus.o_ovf & ~s3_fram) | sat;
    end
endmodule
